zapper_reticule: RTL and testbench
==================================

Name: zapper_reticule

Overview:
- Light-gun (Zapper) front end sitting directly upstream of the video output stage.
- Tracks a crosshair position from mouse deltas or an absolute analog stick, and drives the `reticule` flag the video stage uses to force the crosshair colour.
- Senses "light" by watching the PPU colour index stream at the crosshair position, and generates a debounced trigger pulse for the controller port logic.

Parameters:
- RET_SIZE, 3: crosshair arm half-length in pixels.
- LIGHT_RADIUS, 2: half-width in pixels of the square light-sense window.
- LIGHT_HOLD, 26: scanlines that `light` stays asserted after the last bright hit.
- TRIG_FRAMES, 3: minimum frames `trigger` stays high per press.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- pix_ce  in  1  pixel strobe; color/count_h/count_v are valid on this cycle
- enable  in  1  Zapper selected; when 0, reticule/light/trigger are forced 0
- color  in  6  PPU palette index of the current pixel
- count_h  in  9  PPU dot counter, 0..340
- count_v  in  9  PPU line counter (511 = pre-render line)
- mouse_strobe  in  1  one-cycle pulse: new mouse packet
- mouse_dx  in  9  signed X delta, positive = right
- mouse_dy  in  9  signed Y delta, positive = up
- mouse_btn  in  1  mouse left button, asynchronous to the video timing
- analog_en  in  1  1 = absolute positioning from analog_x/analog_y
- analog_x  in  8  absolute X, 0..255
- analog_y  in  8  absolute Y, 0..255, scaled into 0..239
- reticule  out  1  current pixel lies on the crosshair
- light  out  1  light sensed (active-high; the port logic inverts it)
- trigger  out  1  trigger pulled
- pos_x  out  8  current crosshair X, 0..255
- pos_y  out  8  current crosshair Y, 0..239

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - pos_x=128, pos_y=120.
  - Pending accumulators = 0, hold counter = 0, frame counter = 0, trigger FSM = IDLE.
  - reticule=0, light=0, trigger=0.
  - Reset mid-frame or mid-press discards all state; no pulse completes after reset.
- Frame start event (FS) = pix_ce && count_v==241 && count_h==0.
- Line start event (LS) = pix_ce && count_h==0.

Position, mouse mode (analog_en=0):
- Each mouse_strobe adds dx to pend_x and subtracts dy from pend_y.
- pend_x/pend_y are 11-bit signed, saturating at ±1023.
- At FS: pos_x = clamp(pos_x+pend_x, 0, 255), pos_y = clamp(pos_y+pend_y, 0, 239); both pend registers clear.
- mouse_strobe coincident with FS: that packet's delta is applied in the same update, and pend ends at 0.

Position, analog mode (analog_en=1):
- At FS: pos_x = analog_x, pos_y = (analog_y*15)>>4.
- pend registers are held at 0.
- Switching modes takes effect at the next FS only.

Visible area:
- vis = count_h<256 && count_v<240.

Reticule:
- Registered on pix_ce; valid from the cycle after pix_ce until the next pix_ce.
- Set to 1 when enable && vis && either:
  - count_v==pos_y && |count_h-pos_x|<=RET_SIZE, or
  - count_h==pos_x && |count_v-pos_y|<=RET_SIZE.
- Otherwise 0.
- Differences are computed in 10-bit signed arithmetic. The arms clip at screen edges and do not wrap.

Light sense:
- bright = color[5:4]>=2 && color[3:0]<=4'hC.
- hit = pix_ce && enable && vis && bright && |count_h-pos_x|<=LIGHT_RADIUS && |count_v-pos_y|<=LIGHT_RADIUS.
- On hit: hold counter is loaded with LIGHT_HOLD.
- Else on LS with counter≠0: counter decrements.
- light = (counter≠0), registered.
- hit and LS on the same cycle: the load wins.
- enable=0 clears the counter.

Trigger:
- mouse_btn passes through a 2-flop synchroniser; a rising edge of the synchronised signal is a press.
- FSM states and transitions:
  - IDLE: on press → PULL, frame counter = TRIG_FRAMES, trigger=1.
  - PULL: frame counter decrements on each FS; when it reaches 0 → HOLD, trigger=0.
  - HOLD: wait until the button is released (synchronised 0) → IDLE.
- Presses during PULL or HOLD are ignored.
- enable=0 forces IDLE and trigger=0.

Test Plan:
- Reset release with no stimulus → pos_x=128, pos_y=120, reticule/light/trigger=0; after 3 frames, reticule is 1 exactly at (125..131,120) and (128,117..123).
- Three mouse_strobe packets dx=+50, dy=+10, then FS → pos_x=255 (clamped from 278), pos_y=90. Then dy=-200 → pos_y=239 after the next FS.
- pos=(100,100), colour stream 0x30 only at h=101, v=99 → light rises the cycle after that pix_ce and falls after exactly 26 line starts. Colour 0x0F at the same spot → light stays 0.
- Button held 10 frames → trigger high for exactly 3 FS events then low. A second press while in HOLD gives no pulse; release then press → new 3-frame pulse.
- analog_en=1, analog_x=255, analog_y=255 → after FS pos_x=255, pos_y=239. Toggling analog_en mid-frame does not change pos before the next FS.
- reset_n low during PULL with light active → trigger and light drop on the next clk edge; pos returns to (128,120).

Source files
------------

// File: rtl/zapper_reticule.sv
// Zapper light-gun front end: crosshair tracking, reticule overlay flag,
// light sensing around the crosshair and a debounced trigger pulse.
module zapper_reticule #(
    parameter int unsigned RET_SIZE     = 3,
    parameter int unsigned LIGHT_RADIUS = 2,
    parameter int unsigned LIGHT_HOLD   = 26,
    parameter int unsigned TRIG_FRAMES  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_ce,
    input  logic       enable,
    input  logic [5:0] color,
    input  logic [8:0] count_h,
    input  logic [8:0] count_v,
    input  logic       mouse_strobe,
    input  logic [8:0] mouse_dx,
    input  logic [8:0] mouse_dy,
    input  logic       mouse_btn,
    input  logic       analog_en,
    input  logic [7:0] analog_x,
    input  logic [7:0] analog_y,
    output logic       reticule,
    output logic       light,
    output logic       trigger,
    output logic [7:0] pos_x,
    output logic [7:0] pos_y
);

    localparam int unsigned PEND_W = 11;
    localparam int unsigned SUM_W  = 13;
    localparam int unsigned DIFF_W = 10;
    localparam int unsigned HOLD_W = $clog2(LIGHT_HOLD + 1);
    localparam int unsigned FRM_W  = $clog2(TRIG_FRAMES + 1);

    localparam logic signed [SUM_W-1:0] PEND_MAX = 13'sd1023;
    localparam logic signed [SUM_W-1:0] PEND_MIN = -13'sd1023;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PULL = 2'd1,
        ST_HOLD = 2'd2
    } trig_state_e;

    // Registers
    logic [7:0]               pos_x_q, pos_x_d;
    logic [7:0]               pos_y_q, pos_y_d;
    logic signed [PEND_W-1:0] pend_x_q, pend_x_d;
    logic signed [PEND_W-1:0] pend_y_q, pend_y_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     light_q, light_d;
    logic                     reticule_q, reticule_d;
    logic                     btn_s1_q, btn_s1_d;
    logic                     btn_s2_q, btn_s2_d;
    logic                     btn_prev_q, btn_prev_d;
    trig_state_e              state_q, state_d;
    logic [FRM_W-1:0]         frm_q, frm_d;
    logic                     trigger_q, trigger_d;

    // Combinational helpers
    logic                     frame_start_c;
    logic                     line_start_c;
    logic                     vis_c;
    logic                     bright_c;
    logic                     hit_c;
    logic                     press_c;
    logic signed [DIFF_W-1:0] dh_c, dv_c;
    logic [DIFF_W-1:0]        adh_c, adv_c;
    logic signed [SUM_W-1:0]  pend_x_ext_c, pend_y_ext_c;
    logic signed [SUM_W-1:0]  dx_ext_c, dy_ext_c;
    logic signed [SUM_W-1:0]  acc_x_c, acc_y_c;
    logic signed [PEND_W-1:0] sat_x_c, sat_y_c;
    logic signed [SUM_W-1:0]  sum_x_c, sum_y_c;
    logic [11:0]              ay15_c;

    function automatic logic signed [PEND_W-1:0] sat_pend(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] r;
        r = v;
        if (v > PEND_MAX) r = PEND_MAX;
        if (v < PEND_MIN) r = PEND_MIN;
        return r[PEND_W-1:0];
    endfunction

    function automatic logic [7:0] clamp_pos(input logic signed [SUM_W-1:0] v,
                                             input logic [7:0]              max_v);
        logic [7:0] r;
        if (v[SUM_W-1]) r = 8'd0;
        else if (v > $signed({5'b0, max_v})) r = max_v;
        else r = v[7:0];
        return r;
    endfunction

    assign frame_start_c = pix_ce && (count_v == 9'd241) && (count_h == 9'd0);
    assign line_start_c  = pix_ce && (count_h == 9'd0);
    assign vis_c         = (count_h < 9'd256) && (count_v < 9'd240);
    assign bright_c      = (color[5:4] >= 2'd2) && (color[3:0] <= 4'hC);

    // Screen-space distance from the crosshair; 10-bit signed so arms never wrap
    assign dh_c  = $signed({1'b0, count_h}) - $signed({2'b0, pos_x_q});
    assign dv_c  = $signed({1'b0, count_v}) - $signed({2'b0, pos_y_q});
    assign adh_c = dh_c[DIFF_W-1] ? DIFF_W'(-dh_c) : DIFF_W'(dh_c);
    assign adv_c = dv_c[DIFF_W-1] ? DIFF_W'(-dv_c) : DIFF_W'(dv_c);

    assign hit_c = pix_ce && enable && vis_c && bright_c &&
                   (adh_c <= DIFF_W'(LIGHT_RADIUS)) && (adv_c <= DIFF_W'(LIGHT_RADIUS));

    assign press_c = btn_s2_q && !btn_prev_q;

    // Pending deltas including a packet that lands on this very cycle
    assign pend_x_ext_c = {{(SUM_W-PEND_W){pend_x_q[PEND_W-1]}}, pend_x_q};
    assign pend_y_ext_c = {{(SUM_W-PEND_W){pend_y_q[PEND_W-1]}}, pend_y_q};
    assign dx_ext_c     = {{(SUM_W-9){mouse_dx[8]}}, mouse_dx};
    assign dy_ext_c     = {{(SUM_W-9){mouse_dy[8]}}, mouse_dy};
    assign acc_x_c      = mouse_strobe ? (pend_x_ext_c + dx_ext_c) : pend_x_ext_c;
    assign acc_y_c      = mouse_strobe ? (pend_y_ext_c - dy_ext_c) : pend_y_ext_c;
    assign sat_x_c      = sat_pend(acc_x_c);
    assign sat_y_c      = sat_pend(acc_y_c);
    assign sum_x_c      = $signed({5'b0, pos_x_q}) +
                          $signed({{(SUM_W-PEND_W){sat_x_c[PEND_W-1]}}, sat_x_c});
    assign sum_y_c      = $signed({5'b0, pos_y_q}) +
                          $signed({{(SUM_W-PEND_W){sat_y_c[PEND_W-1]}}, sat_y_c});

    // analog_y * 15 as a shift-subtract; the >>4 is taken by slicing
    assign ay15_c = {analog_y, 4'b0} - {4'b0, analog_y};

    // Crosshair position and pending mouse accumulators
    always_comb begin
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        if (analog_en) begin
            pend_x_d = '0;
            pend_y_d = '0;
        end else begin
            pend_x_d = sat_x_c;
            pend_y_d = sat_y_c;
        end
        if (frame_start_c) begin
            pend_x_d = '0;
            pend_y_d = '0;
            if (analog_en) begin
                pos_x_d = analog_x;
                pos_y_d = ay15_c[11:4];
            end else begin
                pos_x_d = clamp_pos(sum_x_c, 8'd255);
                pos_y_d = clamp_pos(sum_y_c, 8'd239);
            end
        end
    end

    // Reticule overlay and light-hold counter
    always_comb begin
        reticule_d = reticule_q;
        hold_d     = hold_q;
        if (!enable) begin
            reticule_d = 1'b0;
        end else if (pix_ce) begin
            reticule_d = vis_c &&
                         (((dv_c == '0) && (adh_c <= DIFF_W'(RET_SIZE))) ||
                          ((dh_c == '0) && (adv_c <= DIFF_W'(RET_SIZE))));
        end
        if (!enable) begin
            hold_d = '0;
        end else if (hit_c) begin
            hold_d = HOLD_W'(LIGHT_HOLD);
        end else if (line_start_c && (hold_q != '0)) begin
            hold_d = hold_q - HOLD_W'(1);
        end
        light_d = enable && (hold_d != '0);
    end

    // Button synchroniser and edge history
    always_comb begin
        btn_s1_d   = mouse_btn;
        btn_s2_d   = btn_s1_q;
        btn_prev_d = btn_s2_q;
    end

    // Trigger FSM: next state
    always_comb begin
        state_d = state_q;
        frm_d   = frm_q;
        if (!enable) begin
            state_d = ST_IDLE;
            frm_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press_c) begin
                        state_d = ST_PULL;
                        frm_d   = FRM_W'(TRIG_FRAMES);
                    end
                end
                ST_PULL: begin
                    if (frame_start_c) begin
                        frm_d = frm_q - FRM_W'(1);
                        if (frm_q <= FRM_W'(1)) state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!btn_s2_q) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Trigger FSM: output
    always_comb begin
        trigger_d = enable && (state_d == ST_PULL);
    end

    // Trigger FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            frm_q     <= '0;
            trigger_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frm_q     <= frm_d;
            trigger_q <= trigger_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos_x_q    <= 8'd128;
            pos_y_q    <= 8'd120;
            pend_x_q   <= '0;
            pend_y_q   <= '0;
            hold_q     <= '0;
            light_q    <= 1'b0;
            reticule_q <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
            hold_q     <= hold_d;
            light_q    <= light_d;
            reticule_q <= reticule_d;
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign reticule = reticule_q;
    assign light    = light_q;
    assign trigger  = trigger_q;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;

endmodule

// File: tb/tb_zapper_reticule.sv
// Scoreboard bench for zapper_reticule: expectations are queued with each
// stimulus cycle and compared once the DUT has registered that cycle.
module tb_zapper_reticule;

    localparam int SIG_RET   = 0;
    localparam int SIG_LIGHT = 1;
    localparam int SIG_TRIG  = 2;
    localparam int SIG_PX    = 3;
    localparam int SIG_PY    = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pix_ce;
    logic       enable;
    logic [5:0] color;
    logic [8:0] count_h;
    logic [8:0] count_v;
    logic       mouse_strobe;
    logic [8:0] mouse_dx;
    logic [8:0] mouse_dy;
    logic       mouse_btn;
    logic       analog_en;
    logic [7:0] analog_x;
    logic [7:0] analog_y;
    logic       reticule;
    logic       light;
    logic       trigger;
    logic [7:0] pos_x;
    logic [7:0] pos_y;

    int    sig_q[$];
    int    val_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    px_m     = 128;
    int    py_m     = 120;

    zapper_reticule dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pix_ce       (pix_ce),
        .enable       (enable),
        .color        (color),
        .count_h      (count_h),
        .count_v      (count_v),
        .mouse_strobe (mouse_strobe),
        .mouse_dx     (mouse_dx),
        .mouse_dy     (mouse_dy),
        .mouse_btn    (mouse_btn),
        .analog_en    (analog_en),
        .analog_x     (analog_x),
        .analog_y     (analog_y),
        .reticule     (reticule),
        .light        (light),
        .trigger      (trigger),
        .pos_x        (pos_x),
        .pos_y        (pos_y)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int observe(input int sig);
        case (sig)
            SIG_RET:   return int'(reticule);
            SIG_LIGHT: return int'(light);
            SIG_TRIG:  return int'(trigger);
            SIG_PX:    return int'(pos_x);
            default:   return int'(pos_y);
        endcase
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic int ret_model(input int h, input int v);
        if (!(h < 256 && v < 240)) return 0;
        if (v == py_m && iabs(h - px_m) <= 3) return 1;
        if (h == px_m && iabs(v - py_m) <= 3) return 1;
        return 0;
    endfunction

    task automatic expect_sig(input int sig, input int val, input string tag);
        sig_q.push_back(sig);
        val_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    // One clock; compare everything queued for this cycle, then drop strobes
    task automatic tick();
        int    s;
        int    v;
        string t;
        @(posedge clk);
        #1;
        while (sig_q.size() > 0) begin
            s = sig_q.pop_front();
            v = val_q.pop_front();
            t = tag_q.pop_front();
            check(t, observe(s), v);
        end
        pix_ce       = 1'b0;
        mouse_strobe = 1'b0;
    endtask

    task automatic pix(input int h, input int v, input int col, input bit chk_ret);
        count_h = 9'(h);
        count_v = 9'(v);
        color   = 6'(col);
        pix_ce  = 1'b1;
        if (chk_ret) expect_sig(SIG_RET, ret_model(h, v), $sformatf("ret_%0d_%0d", h, v));
        tick();
    endtask

    task automatic fs();
        pix(0, 241, 0, 1'b0);
    endtask

    task automatic strobe(input int dx, input int dy);
        mouse_dx     = 9'(dx);
        mouse_dy     = 9'(dy);
        mouse_strobe = 1'b1;
        tick();
    endtask

    task automatic expect_pos(input int x, input int y, input string tag);
        expect_sig(SIG_PX, x, {tag, "_x"});
        expect_sig(SIG_PY, y, {tag, "_y"});
    endtask

    initial begin
        reset_n = 1'b0; pix_ce = 1'b0; enable = 1'b0; color = '0;
        count_h = '0; count_v = '0; mouse_strobe = 1'b0; mouse_dx = '0;
        mouse_dy = '0; mouse_btn = 1'b0; analog_en = 1'b0; analog_x = '0; analog_y = '0;

        // Reset state
        tick();
        expect_pos(128, 120, "rst_pos");
        expect_sig(SIG_RET, 0, "rst_ret");
        expect_sig(SIG_LIGHT, 0, "rst_light");
        expect_sig(SIG_TRIG, 0, "rst_trig");
        tick();
        reset_n = 1'b1;
        enable  = 1'b1;
        expect_pos(128, 120, "idle_pos");
        expect_sig(SIG_TRIG, 0, "idle_trig");
        tick();

        // Crosshair shape around the centre after a few frames
        for (int f = 0; f < 3; f++) fs();
        expect_pos(128, 120, "frames_pos");
        tick();
        for (int v = 114; v <= 126; v++)
            for (int h = 122; h <= 134; h++)
                pix(h, v, 6'h0F, 1'b1);

        // Mouse accumulation with clamping
        for (int i = 0; i < 3; i++) strobe(50, 10);
        expect_pos(255, 90, "mouse_clamp_x");
        fs();
        strobe(0, -200);
        expect_pos(255, 239, "mouse_clamp_y");
        fs();
        strobe(-100, 100);
        mouse_dx = 9'(-55);
        mouse_dy = 9'(39);
        mouse_strobe = 1'b1;
        expect_pos(100, 100, "coincident");
        fs();
        expect_pos(100, 100, "pend_cleared");
        fs();
        // Accumulator saturation at -1023 is visible once it is walked back
        for (int i = 0; i < 5; i++) strobe(-256, 0);
        for (int i = 0; i < 4; i++) strobe(255, 0);
        strobe(3, 0);
        expect_pos(100, 100, "pend_saturate");
        fs();
        px_m = 100;
        py_m = 100;

        // Light sensing
        expect_sig(SIG_LIGHT, 0, "light_dark");
        pix(100, 99, 6'h0F, 1'b1);
        expect_sig(SIG_LIGHT, 0, "light_pre");
        pix(104, 100, 6'h0F, 1'b1);
        expect_sig(SIG_LIGHT, 1, "light_rise");
        pix(101, 99, 6'h30, 1'b0);
        for (int i = 1; i <= 26; i++) begin
            expect_sig(SIG_LIGHT, (i < 26) ? 1 : 0, $sformatf("light_ls%0d", i));
            pix(0, 99 + i, 6'h00, 1'b0);
            if (i < 26) begin
                expect_sig(SIG_LIGHT, 1, $sformatf("light_mid%0d", i));
                pix(50, 99 + i, 6'h30, 1'b0);
            end
        end
        expect_sig(SIG_LIGHT, 0, "light_0f");
        pix(101, 99, 6'h0F, 1'b0);
        expect_sig(SIG_LIGHT, 0, "light_3d");
        pix(101, 99, 6'h3D, 1'b0);
        expect_sig(SIG_LIGHT, 1, "light_2c_edge");
        pix(102, 102, 6'h2C, 1'b0);
        expect_sig(SIG_LIGHT, 0, "light_out_radius");
        enable = 1'b0;
        expect_sig(SIG_LIGHT, 0, "dis_light");
        expect_sig(SIG_RET, 0, "dis_ret");
        tick();
        enable = 1'b1;
        pix(103, 100, 6'h30, 1'b0);
        tick();
        expect_sig(SIG_LIGHT, 0, "light_r3_miss");
        tick();

        // Trigger pulse: three frames, then wait for release
        mouse_btn = 1'b1;
        expect_sig(SIG_TRIG, 0, "trig_sync1");
        tick();
        expect_sig(SIG_TRIG, 0, "trig_sync2");
        tick();
        expect_sig(SIG_TRIG, 1, "trig_rise");
        tick();
        for (int f = 1; f <= 10; f++) begin
            expect_sig(SIG_TRIG, (f < 3) ? 1 : 0, $sformatf("trig_fs%0d", f));
            fs();
        end
        mouse_btn = 1'b0;
        repeat (4) tick();
        mouse_btn = 1'b1;
        repeat (2) tick();
        expect_sig(SIG_TRIG, 1, "trig2_rise");
        tick();
        expect_sig(SIG_TRIG, 1, "trig2_fs1");
        fs();
        mouse_btn = 1'b0;
        repeat (4) tick();
        mouse_btn = 1'b1;
        repeat (3) tick();
        expect_sig(SIG_TRIG, 1, "trig2_repress");
        tick();
        expect_sig(SIG_TRIG, 1, "trig2_fs2");
        fs();
        expect_sig(SIG_TRIG, 0, "trig2_fs3");
        fs();
        repeat (3) tick();
        expect_sig(SIG_TRIG, 0, "trig2_held");
        tick();
        mouse_btn = 1'b0;
        repeat (4) tick();

        // Analog positioning and mode switching at frame start only
        analog_en = 1'b1;
        analog_x  = 8'd255;
        analog_y  = 8'd255;
        expect_pos(255, 239, "analog_max");
        fs();
        analog_x = 8'd7;
        analog_y = 8'd16;
        expect_pos(7, 15, "analog_scale");
        fs();
        strobe(20, 0);
        analog_en = 1'b0;
        expect_pos(7, 15, "mode_mid_frame");
        pix(30, 30, 6'h00, 1'b0);
        expect_pos(7, 15, "mode_to_mouse");
        fs();
        analog_en = 1'b1;
        analog_x  = 8'd100;
        analog_y  = 8'd107;
        expect_pos(7, 15, "mode_to_analog_mid");
        pix(30, 30, 6'h00, 1'b0);
        expect_pos(100, 100, "mode_to_analog");
        fs();
        analog_en = 1'b0;

        // Reset during a pull with light active
        mouse_btn = 1'b1;
        repeat (2) tick();
        expect_sig(SIG_TRIG, 1, "pre_rst_trig");
        tick();
        expect_sig(SIG_LIGHT, 1, "pre_rst_light");
        pix(100, 100, 6'h30, 1'b0);
        reset_n   = 1'b0;
        mouse_btn = 1'b0;
        expect_sig(SIG_TRIG, 0, "mid_rst_trig");
        expect_sig(SIG_LIGHT, 0, "mid_rst_light");
        expect_pos(128, 120, "mid_rst_pos");
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        expect_sig(SIG_TRIG, 0, "post_rst_trig");
        expect_sig(SIG_LIGHT, 0, "post_rst_light");
        fs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
